// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial add/subtract controller built on one 1-bit full adder
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int IW = $clog2(WIDTH);
  localparam int CW = IW + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  state_t           state_next;
  logic [CW-1:0]    cnt;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] res_reg;
  logic [WIDTH-1:0] res_next;
  logic             carry;
  logic             fa_a;
  logic             fa_b;
  logic             fa_s;
  logic             fa_c;
  logic             load;
  logic             last;

  assign idx  = cnt[IW-1:0];
  assign last = (cnt == LAST_CNT);
  assign load = start && ((state == IDLE) || (state == DONE));

  // The single full adder shared by every bit position
  assign fa_a = a_reg[idx];
  assign fa_b = b_reg[idx];
  assign fa_s = fa_a ^ fa_b ^ carry;
  assign fa_c = (fa_a & fa_b) | (carry & (fa_a ^ fa_b));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        if (last) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = start ? SHIFT : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    res_next      = res_reg;
    res_next[idx] = fa_s;
  end

  // Partial results stay internal; sum/cout/ovf only move on the DONE entry edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt     <= '0;
      a_reg   <= '0;
      b_reg   <= '0;
      res_reg <= '0;
      carry   <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else if (load) begin
      a_reg <= op_a;
      b_reg <= sub ? ~op_b : op_b;
      carry <= sub ? 1'b1 : cin;
      cnt   <= '0;
    end else if (state == SHIFT) begin
      res_reg <= res_next;
      carry   <= fa_c;
      cnt     <= cnt + 1'b1;
      if (last) begin
        sum  <= res_next;
        cout <= fa_c;
        ovf  <= carry ^ fa_c;
      end
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - directed self-checking bench for serial_add_ctrl (WIDTH=8)
module tb_serial_add_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       sub;
  logic [7:0] op_a;
  logic [7:0] op_b;
  logic       cin;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       cout;
  logic       ovf;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_sum_prev;

  serial_add_ctrl #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .sub   (sub),
    .op_a  (op_a),
    .op_b  (op_b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Starts one operation and follows it to its done pulse, checking latency and busy width
  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic s, input logic c, input logic [7:0] es,
                        input logic ec, input logic eo);
    int n;
    int busy_cnt;
    int both;
    int leak;
    op_a = a; op_b = b; sub = s; cin = c; start = 1'b1;
    step();
    start = 1'b0;
    n = 1; busy_cnt = 0; both = 0; leak = 0;
    while (!done && n < 20) begin
      if (busy) busy_cnt++;
      if (busy && done) both++;
      if (sum !== exp_sum_prev) leak++;
      step();
      n++;
    end
    check({tag, "_edges"}, n, 9);
    check({tag, "_busy_cycles"}, busy_cnt, 8);
    check({tag, "_busy_done_overlap"}, both, 0);
    check({tag, "_sum_hold_in_shift"}, leak, 0);
    check({tag, "_sum"}, sum, es);
    check({tag, "_cout"}, cout, ec);
    check({tag, "_ovf"}, ovf, eo);
    check({tag, "_busy_in_done"}, busy, 0);
    exp_sum_prev = es;
    step();
    check({tag, "_done_single"}, done, 0);
    check({tag, "_sum_hold_idle"}, sum, es);
  endtask

  initial begin
    int n;
    int done_cnt;
    rst_n = 1'b0; start = 1'b0; sub = 1'b0; op_a = 8'h00; op_b = 8'h00; cin = 1'b0;
    exp_sum_prev = 8'h00;
    step();
    step();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    check("rst_ovf", ovf, 0);
    rst_n = 1'b1;
    step();
    check("idle_done", done, 0);

    run_op("add_0_0", 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    run_op("add_7f_00_c1", 8'h7F, 8'h00, 1'b0, 1'b1, 8'h80, 1'b0, 1'b1);
    run_op("sub_05_07", 8'h05, 8'h07, 1'b1, 1'b0, 8'hFE, 1'b0, 1'b0);
    run_op("sub_80_01", 8'h80, 8'h01, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b1);
    run_op("sub_10_10_cin_ignored", 8'h10, 8'h10, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0);

    // start pulsed with different operands during SHIFT cycle 3
    op_a = 8'h11; op_b = 8'h22; sub = 1'b0; cin = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    op_a = 8'hAA; op_b = 8'hBB; sub = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    n = 4; done_cnt = 0;
    while (!done && n < 20) begin step(); n++; end
    check("ign_edges", n, 9);
    check("ign_sum", sum, 8'h33);
    check("ign_cout", cout, 0);
    check("ign_ovf", ovf, 0);
    for (int i = 0; i < 12; i++) begin
      step();
      if (done) done_cnt++;
    end
    check("ign_no_second_done", done_cnt, 0);

    // start held high: first op result, then back-to-back op from DONE
    op_a = 8'h01; op_b = 8'h02; sub = 1'b0; cin = 1'b0; start = 1'b1;
    step();
    op_a = 8'h40; op_b = 8'h40;
    n = 1;
    while (!done && n < 20) begin step(); n++; end
    check("b2b_first_edges", n, 9);
    check("b2b_first_sum", sum, 8'h03);
    step();
    n = 1;
    while (!done && n < 20) begin step(); n++; end
    start = 1'b0;
    check("b2b_gap_edges", n, 9);
    check("b2b_second_sum", sum, 8'h80);
    check("b2b_second_cout", cout, 0);
    check("b2b_second_ovf", ovf, 1);
    step();
    check("b2b_done_low", done, 0);

    // reset for one edge during SHIFT cycle 5
    op_a = 8'h55; op_b = 8'h55; sub = 1'b0; cin = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_sum", sum, 0);
    check("mid_rst_cout", cout, 0);
    check("mid_rst_ovf", ovf, 0);
    done_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (done || busy) done_cnt++;
    end
    check("mid_rst_no_done", done_cnt, 0);
    exp_sum_prev = 8'h00;
    run_op("post_rst_12_34", 8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
